mac6_acc: RTL

Accumulator stage directly downstream of the 3-bit array multiplier. Consumes the 6-bit unsigned products it emits, sums a fixed number of them (`N_TERMS`), and presents the total on a valid/ready output port. Together the pair forms a small dot-product unit. A sticky flag reports modular wrap of the accumulator.

---
 rtl/mac6_pkg.sv | 12 +
 rtl/mac6_acc_acc_reg.sv | 50 +++++
 rtl/mac6_acc.sv | 83 ++++++++
 3 files changed

// File: rtl/mac6_pkg.sv
// Shared types and constants for the 6-bit product accumulator.
package mac6_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } mac_state_t;

    localparam int PROD_W   = 6;
    localparam int PROD_MAX = 49;

endpackage

// File: rtl/mac6_acc_acc_reg.sv
// ACC_W-bit accumulator register with carry-out detection and a sticky wrap flag.
module acc_reg
    import mac6_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [PROD_W-1:0] addend_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_w;

    // One extra bit on the adder captures the carry out of the top accumulator bit.
    assign sum_w = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend_i};

    // NOTE: every next-state signal is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_i) begin
            acc_d = sum_w[ACC_W-1:0];
            ovf_d = ovf_q | sum_w[ACC_W];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac6_acc.sv
// Sums N_TERMS unsigned 6-bit products and presents the total on a valid/ready port.
module mac6_acc
    import mac6_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);

    localparam int                CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_TERMS - 1);

    mac_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             out_hs;

    // Internal accept uses state only; holding in_ready low during reset is an output-only concern.
    assign accept    = in_valid && (state_q == ACCUM);
    assign out_hs    = out_valid && out_ready;
    assign in_ready  = rst_n && (state_q == ACCUM);
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state_d = ACCUM;
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear wins over a same-cycle accept; the output handshake empties the sum for the next result.
    acc_reg #(
        .ACC_W(ACC_W)
    ) u_acc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clear | out_hs),
        .add_i    (accept & ~clear),
        .addend_i (prod),
        .acc_o    (acc_out),
        .ovf_o    (ovf)
    );

endmodule
